// File: rtl/paddle_pot_emu.sv
// Multi-channel paddle potentiometer emulator: per-frame latched positions from
// digital/analog sources, per-channel line counters and registered comparator pulses.
module paddle_pot_emu #(
  parameter int NCH         = 2,
  parameter int PW          = 8,
  parameter int DEFAULT_POS = 114,
  parameter int ACC_HOLD    = 8,
  localparam int SW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              vsync_pulse,
  input  logic              hsync_pulse,
  input  logic              pad_en_n,
  input  logic [SW-1:0]     sel,
  input  logic [3*NCH-1:0]  mode,
  input  logic [2*NCH-1:0]  speed,
  input  logic [NCH-1:0]    dig_left,
  input  logic [NCH-1:0]    dig_right,
  input  logic [PW*NCH-1:0] analog_in,
  output logic [PW*NCH-1:0] pos_out,
  output logic [NCH-1:0]    pad_out_all,
  output logic              pad_out
);

  localparam logic [PW+1:0] ACC_MAX = {2'b00, {PW{1'b1}}};
  localparam logic [PW-1:0] POS_DEF = PW'(DEFAULT_POS);

  logic [PW-1:0] r_pos [NCH];
  logic [NCH-1:0] w_cmp;
  logic           w_sel_cmp;
  logic [NCH-1:0] r_pad_all;
  logic           r_pad;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [2:0]    w_mode;
    logic [1:0]    w_speed;
    logic          w_l, w_r;
    logic [PW-1:0] w_ana, w_offs, w_src, w_acc_nx, w_cnt_nx;
    logic [3:0]    w_hold_nx;
    logic [PW+1:0] w_step, w_sum;
    logic [3:0]    r_hold;
    logic [PW-1:0] r_acc, r_cnt;

    assign w_mode  = mode[3*i +: 3];
    assign w_speed = speed[2*i +: 2];
    assign w_l     = dig_left[i];
    assign w_r     = dig_right[i];
    assign w_ana   = analog_in[PW*i +: PW];
    assign w_offs  = {~w_ana[PW-1], w_ana[PW-2:0]};
    assign w_sum   = {2'b00, r_acc} + w_step;

    always_comb begin
      w_hold_nx = 4'd0;
      if (w_l ^ w_r) w_hold_nx = (r_hold == 4'd15) ? 4'd15 : r_hold + 4'd1;
      w_step = (PW+2)'(2) << w_speed;
      // Acceleration keys off the hold count this frame will store.
      if (32'(w_hold_nx) >= ACC_HOLD) w_step = w_step << 1;

      w_acc_nx = r_acc;
      if (w_l && !w_r)
        w_acc_nx = (w_sum > ACC_MAX) ? {PW{1'b1}} : w_sum[PW-1:0];
      else if (w_r && !w_l)
        w_acc_nx = ({2'b00, r_acc} < w_step) ? '0 : r_acc - w_step[PW-1:0];

      case (w_mode)
        3'd0:    w_src = w_acc_nx;
        3'd1:    w_src = ~w_offs;
        3'd2:    w_src = w_offs;
        3'd3:    w_src = ~w_ana;
        3'd4:    w_src = w_ana;
        default: w_src = POS_DEF;
      endcase

      w_cnt_nx = r_cnt;
      if (!pad_en_n)                               w_cnt_nx = '0;
      else if (hsync_pulse && r_cnt != {PW{1'b1}}) w_cnt_nx = r_cnt + PW'(1);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        r_hold   <= 4'd0;
        r_acc    <= POS_DEF;
        r_pos[i] <= POS_DEF;
        r_cnt    <= '0;
      end else begin
        r_cnt <= w_cnt_nx;
        if (vsync_pulse) begin
          r_hold   <= w_hold_nx;
          r_pos[i] <= w_src;
          // Outside digital mode the accumulator shadows the latched position.
          r_acc    <= (w_mode == 3'd0) ? w_acc_nx : w_src;
        end
      end
    end

    assign w_cmp[i]             = (r_cnt < r_pos[i]);
    assign pos_out[PW*i +: PW]  = r_pos[i];
  end

  always_comb begin
    w_sel_cmp = w_cmp[0];
    for (int i = 0; i < NCH; i++)
      if (sel == SW'(i)) w_sel_cmp = w_cmp[i];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_pad_all <= '0;
      r_pad     <= 1'b0;
    end else begin
      r_pad_all <= w_cmp;
      r_pad     <= w_sel_cmp;
    end
  end

  assign pad_out_all = r_pad_all;
  assign pad_out     = r_pad;

endmodule

// File: tb/tb_paddle_pot_emu.sv
// Directed bench for paddle_pot_emu: expected values are queued when stimulus
// is driven and popped at each sample point.
module tb_paddle_pot_emu;

  localparam int NCH = 2;
  localparam int PW  = 8;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              vsync_pulse, hsync_pulse, pad_en_n;
  logic [0:0]        sel;
  logic [3*NCH-1:0]  mode;
  logic [2*NCH-1:0]  speed;
  logic [NCH-1:0]    dig_left, dig_right;
  logic [PW*NCH-1:0] analog_in;
  logic [PW*NCH-1:0] pos_out;
  logic [NCH-1:0]    pad_out_all;
  logic              pad_out;

  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int left_tbl[10] = '{118, 122, 126, 130, 134, 138, 142, 150, 158, 166};

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  paddle_pot_emu #(.NCH(NCH), .PW(PW), .DEFAULT_POS(114), .ACC_HOLD(8)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .vsync_pulse(vsync_pulse),
    .hsync_pulse(hsync_pulse), .pad_en_n(pad_en_n), .sel(sel), .mode(mode),
    .speed(speed), .dig_left(dig_left), .dig_right(dig_right),
    .analog_in(analog_in), .pos_out(pos_out), .pad_out_all(pad_out_all),
    .pad_out(pad_out)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic frame();
    vsync_pulse = 1'b1;
    tick();
    vsync_pulse = 1'b0;
  endtask

  // scoreboard
  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL %s: observed %0d but no expected value queued", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        n_bad++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; vsync_pulse = 1'b0; hsync_pulse = 1'b0; pad_en_n = 1'b1;
    sel = 1'b0; mode = '0; speed = '0; dig_left = '0; dig_right = '0; analog_in = '0;
    repeat (3) tick();

    // reset state
    push(114); check("rst_pos0", 32'(pos_out[7:0]));
    push(114); check("rst_pos1", 32'(pos_out[15:8]));
    push(0);   check("rst_pad_all", 32'(pad_out_all));
    reset_n = 1'b1;
    tick();
    push(2'b11); check("post_rst_pad_all", 32'(pad_out_all));
    push(1);     check("post_rst_pad", 32'(pad_out));

    // digital left with acceleration
    mode[2:0] = 3'd0; speed[1:0] = 2'd1; dig_left[0] = 1'b1;
    for (int f = 0; f < 10; f++) begin
      push(32'(left_tbl[f]));
      frame();
      check("left_accel", 32'(pos_out[7:0]));
    end
    dig_left[0] = 1'b0;
    push(166); frame(); check("left_release", 32'(pos_out[7:0]));
    dig_left[0] = 1'b1;
    push(170); frame(); check("hold_restart", 32'(pos_out[7:0]));
    dig_right[0] = 1'b1;
    push(170); frame(); check("both_held", 32'(pos_out[7:0]));
    dig_left[0] = 1'b0; dig_right[0] = 1'b0;

    // saturation at both ends
    mode[2:0] = 3'd4; analog_in[7:0] = 8'd250;
    push(250); frame(); check("load_250", 32'(pos_out[7:0]));
    mode[2:0] = 3'd0; speed[1:0] = 2'd3; dig_left[0] = 1'b1;
    push(255); frame(); check("sat_hi", 32'(pos_out[7:0]));
    push(255); frame(); check("sat_hi_hold", 32'(pos_out[7:0]));
    dig_left[0] = 1'b0;
    mode[2:0] = 3'd4; analog_in[7:0] = 8'd6;
    push(6); frame(); check("load_6", 32'(pos_out[7:0]));
    mode[2:0] = 3'd0; dig_right[0] = 1'b1;
    push(0); frame(); check("sat_lo", 32'(pos_out[7:0]));
    push(0); frame(); check("sat_lo_hold", 32'(pos_out[7:0]));
    dig_right[0] = 1'b0;

    // ch1 analog modes and mid-frame isolation
    mode[5:3] = 3'd1; analog_in[15:8] = 8'h80;
    push(8'hFF); frame(); check("x_min", 32'(pos_out[15:8]));
    analog_in[15:8] = 8'h7F;
    tick();
    push(8'hFF); check("x_midframe", 32'(pos_out[15:8]));
    push(8'h00); frame(); check("x_max", 32'(pos_out[15:8]));
    mode[5:3] = 3'd2;
    push(8'hFF); frame(); check("xinv", 32'(pos_out[15:8]));
    mode[5:3] = 3'd3; analog_in[15:8] = 8'h30;
    push(8'hCF); frame(); check("paddle", 32'(pos_out[15:8]));
    mode[5:3] = 3'd6;
    push(114); frame(); check("fixed_mode", 32'(pos_out[15:8]));

    // line counter vs position 114, counter saturation
    mode[2:0] = 3'd4; analog_in[7:0] = 8'd114;
    mode[5:3] = 3'd4; analog_in[15:8] = 8'd200;
    frame();
    pad_en_n = 1'b0; tick(); pad_en_n = 1'b1; tick();
    push(1); check("line0_pad", 32'(pad_out));
    for (int k = 1; k <= 300; k++) begin
      hsync_pulse = 1'b1; tick(); hsync_pulse = 1'b0; tick();
      push(32'(((k < 255) ? k : 255) < 114)); check("line_pad", 32'(pad_out));
      push(32'(((k < 255) ? k : 255) < 200)); check("line_pad_ch1", 32'(pad_out_all[1]));
    end
    pad_en_n = 1'b0; tick(); tick();
    push(1); check("pad_en_clear", 32'(pad_out));

    // simultaneous vsync and hsync
    pad_en_n = 1'b1; analog_in[7:0] = 8'd1;
    vsync_pulse = 1'b1; hsync_pulse = 1'b1; tick();
    vsync_pulse = 1'b0; hsync_pulse = 1'b0;
    push(1); check("simul_pos", 32'(pos_out[7:0]));
    tick();
    push(0); check("simul_pad", 32'(pad_out_all[0]));

    // paddle to digital handover, then channel select
    mode[2:0] = 3'd3; analog_in[7:0] = 8'd55; analog_in[15:8] = 8'd0;
    push(200); frame(); check("paddle_200", 32'(pos_out[7:0]));
    mode[2:0] = 3'd0; speed[1:0] = 2'd0; dig_left[0] = 1'b1;
    push(202); frame(); check("no_jump", 32'(pos_out[7:0]));
    dig_left[0] = 1'b0;
    pad_en_n = 1'b0; tick(); tick();
    push(2'b01); check("sel_pad_all", 32'(pad_out_all));
    push(1);     check("sel0_pad", 32'(pad_out));
    sel = 1'b1;
    #1;
    push(1); check("sel_before_edge", 32'(pad_out));
    tick();
    push(0); check("sel1_pad", 32'(pad_out));

    // reset mid-frame
    #2 reset_n = 1'b0;
    #1;
    push(16'h7272); check("midrst_pos", 32'(pos_out));
    push(0);        check("midrst_pad_all", 32'(pad_out_all));
    push(0);        check("midrst_pad", 32'(pad_out));
    tick(); reset_n = 1'b1; tick();
    push(2'b11); check("midrst_release", 32'(pad_out_all));
    mode[5:3] = 3'd0;
    push(114); frame(); check("midrst_acc", 32'(pos_out[7:0]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
